// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, depth default and FSM state encoding for the divide issuer
package div_pkg;

    localparam int DIV_DEPTH  = 4;
    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int RESULT_W   = 4;
    localparam int FIFO_W     = DIVIDEND_W + DIVISOR_W;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE      = 2'd0;
    localparam div_state_t ST_WAIT_BUSY = 2'd1;
    localparam div_state_t ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - operand stream, divider handshake and result stream bundle
interface div_if;
    import div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] in_word1;
    logic [DIVISOR_W-1:0]  in_word2;

    logic                  div_start;
    logic [DIVIDEND_W-1:0] div_word1;
    logic [DIVISOR_W-1:0]  div_word2;
    logic                  div_ready;
    logic [RESULT_W-1:0]   div_quotient;
    logic [RESULT_W-1:0]   div_remainder;

    logic                  out_valid;
    logic                  out_ready;
    logic [RESULT_W-1:0]   out_quotient;
    logic [RESULT_W-1:0]   out_remainder;
    logic                  out_dbz;

    // Environment side: operand producer, divider and result consumer
    modport master (
        output in_valid, in_word1, in_word2,
        output div_ready, div_quotient, div_remainder,
        output out_ready,
        input  in_ready, div_start, div_word1, div_word2,
        input  out_valid, out_quotient, out_remainder, out_dbz
    );

    // Issuer side
    modport slave (
        input  in_valid, in_word1, in_word2,
        input  div_ready, div_quotient, div_remainder,
        input  out_ready,
        output in_ready, div_start, div_word1, div_word2,
        output out_valid, out_quotient, out_remainder, out_dbz
    );

endinterface

// File: rtl/div_fifo.sv
// rtl/div_fifo.sv - operand pair FIFO, head visible combinationally
module div_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = DIV_DEPTH,
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_issue.sv
// rtl/div_issue.sv - queues operand pairs and issues them one at a time to a sequential divider
module div_issue
    import div_pkg::*;
#(
    parameter int DEPTH = DIV_DEPTH
) (
    input logic   clk,
    input logic   reset,
    div_if.slave  bus
);

    logic [FIFO_W-1:0]     head;
    logic [DIVIDEND_W-1:0] head_word1;
    logic [DIVISOR_W-1:0]  head_word2;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  can_issue;
    logic                  take_div;
    logic                  take_dbz;
    logic                  capture;

    div_state_t            state;
    logic                  res_valid;
    logic [RESULT_W-1:0]   res_quotient;
    logic [RESULT_W-1:0]   res_remainder;
    logic                  res_dbz;

    assign push        = bus.in_valid && !fifo_full;
    assign bus.in_ready = !fifo_full;

    div_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_word1, bus.in_word2}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_word1, head_word2} = head;
    assign bus.div_word1 = head_word1;
    assign bus.div_word2 = head_word2;

    // A head is only consumed when the single result slot is free and no divide is outstanding
    assign can_issue = (state == ST_IDLE) && !fifo_empty && !res_valid;
    assign take_div  = can_issue && (head_word2 != '0) && bus.div_ready;
    assign take_dbz  = can_issue && (head_word2 == '0);
    assign pop       = take_div || take_dbz;
    assign capture   = (state == ST_WAIT_DONE) && bus.div_ready;

    assign bus.div_start = take_div;

    // Issue FSM: wait for the divider to drop ready (accepted) then raise it again (done)
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_div) begin
                        state <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!bus.div_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.div_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result slot: loaded by a divide-by-zero bypass or a divider completion, freed by the consumer
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid     <= 1'b0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_dbz       <= 1'b0;
        end else if (take_dbz) begin
            res_valid     <= 1'b1;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_dbz       <= 1'b1;
        end else if (capture) begin
            res_valid     <= 1'b1;
            res_quotient  <= bus.div_quotient;
            res_remainder <= bus.div_remainder;
            res_dbz       <= 1'b0;
        end else if (res_valid && bus.out_ready) begin
            res_valid     <= 1'b0;
        end
    end

    assign bus.out_valid     = res_valid;
    assign bus.out_quotient  = res_quotient;
    assign bus.out_remainder = res_remainder;
    assign bus.out_dbz       = res_dbz;

endmodule

// File: tb/tb_div_issue.sv
// tb/tb_div_issue.sv - randomized and directed checks of div_issue against a queue-based reference
module tb_div_issue;
    import div_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
    } pair_t;

    logic clk = 1'b0;
    logic reset;

    int n_total = 0;
    int n_pass  = 0;

    int    pre_hold    = 0;
    int    busy_starts = 0;
    logic  dm_busy;
    int    dm_pre;
    int    dm_cnt;
    logic [7:0] dm_a;
    logic [3:0] dm_b;

    pair_t exp_q[$];
    pair_t mon_p;

    always #5 clk = ~clk;

    div_if bus();

    div_issue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signed truncating division; remainder takes the dividend's sign
    function automatic logic [8:0] ref_result(input logic [7:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int q;
        int r;
        if (b == 4'd0) begin
            return 9'h100;
        end
        ia = int'($signed(a));
        ib = int'($signed(b));
        q  = ia / ib;
        r  = ia % ib;
        return {1'b0, q[3:0], r[3:0]};
    endfunction

    // Sequential divider: optional extra ready-high cycles after start, then 4 busy cycles
    always @(posedge clk) begin
        if (reset) begin
            bus.div_ready     <= 1'b1;
            bus.div_quotient  <= 4'd0;
            bus.div_remainder <= 4'd0;
            dm_busy           <= 1'b0;
            dm_pre            <= 0;
            dm_cnt            <= 0;
        end else if (!dm_busy) begin
            if (bus.div_start) begin
                dm_a    <= bus.div_word1;
                dm_b    <= bus.div_word2;
                dm_busy <= 1'b1;
                dm_pre  <= pre_hold;
                dm_cnt  <= 4;
                if (pre_hold == 0) bus.div_ready <= 1'b0;
            end
        end else begin
            if (bus.div_start) busy_starts <= busy_starts + 1;
            if (dm_pre > 0) begin
                dm_pre <= dm_pre - 1;
                if (dm_pre == 1) bus.div_ready <= 1'b0;
            end else if (dm_cnt > 1) begin
                dm_cnt <= dm_cnt - 1;
            end else begin
                bus.div_ready                            <= 1'b1;
                {bus.div_quotient, bus.div_remainder}    <= ref_result(dm_a, dm_b) ^ 9'h0 ;
                dm_busy                                  <= 1'b0;
            end
        end
    end

    // Scoreboard: accepted pairs queue in order, each consumed result must match the queue head
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check_eq("out_expected_present", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_p = exp_q.pop_front();
                    check_eq("out_result", 32'({bus.out_dbz, bus.out_quotient, bus.out_remainder}),
                             32'(ref_result(mon_p.a, mon_p.b)));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{bus.in_word1, bus.in_word2});
            end
        end
    end

    // One operation into an idle block; exp_start < 0 means no start pulse is allowed
    task automatic run_one(input logic [7:0] a, input logic [3:0] b, input int exp_start, input int exp_out);
        int st = -1;
        int ov = -1;
        int starts = 0;
        bus.in_valid = 1'b1;
        bus.in_word1 = a;
        bus.in_word2 = b;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) check_eq("accept_ready", 32'(bus.in_ready), 32'd1);
            if (bus.div_start) begin
                starts++;
                if (st < 0) begin
                    st = k;
                    check_eq("start_word1", 32'(bus.div_word1), 32'(a));
                    check_eq("start_word2", 32'(bus.div_word2), 32'(b));
                end
            end
            if (bus.out_valid && ov < 0) ov = k;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        check_eq("start_cycle", 32'(st), 32'(exp_start));
        check_eq("start_count", 32'(starts), (exp_start < 0) ? 32'd0 : 32'd1);
        check_eq("out_cycle", 32'(ov), 32'(exp_out));
    endtask

    task automatic test_stall();
        logic [8:0] snap;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word1  = 8'd100;
        bus.in_word2  = 4'd7;
        @(posedge clk); #1;
        bus.in_word1  = 8'hF0;
        bus.in_word2  = 4'd5;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk); #1;
        end
        check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
        snap = {bus.out_dbz, bus.out_quotient, bus.out_remainder};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("stall_hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("stall_hold_data", 32'({bus.out_dbz, bus.out_quotient, bus.out_remainder}), 32'(snap));
            check_eq("stall_no_start", 32'(bus.div_start), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("stall_release_issue", 32'(bus.div_start), 32'd1);
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        int   accepted = 0;
        logic need = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (need) begin
                bus.in_word1 = 8'($urandom);
                bus.in_word2 = 4'($urandom);
                need = 1'b0;
            end
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) begin
                accepted++;
                need = 1'b1;
            end
            @(posedge clk); #1;
        end
        check_eq("fill_accepted", 32'(accepted), 32'(DEPTH + 1));
        @(negedge clk);
        check_eq("fill_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        if (need) begin
            bus.in_word1 = 8'($urandom);
            bus.in_word2 = 4'($urandom);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted++;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check_eq("fill_last_accepted", 32'(accepted), 32'(DEPTH + 2));
        repeat ((DEPTH + 2) * 8 + 10) @(posedge clk);
        #1;
        check_eq("fill_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_reset();
        int seen = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word1  = 8'd50;
        bus.in_word2  = 4'd7;
        @(posedge clk); #1;
        bus.in_word1  = 8'd33;
        bus.in_word2  = 4'd2;
        @(posedge clk); #1;
        bus.in_word1  = 8'd90;
        bus.in_word2  = 4'd0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_prior_state", 32'(dut.state), 32'(ST_WAIT_DONE));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_state", 32'(dut.state), 32'(ST_IDLE));
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.out_valid || bus.div_start) seen++;
        end
        check_eq("rst_no_stale_result", 32'(seen), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [3:0] rb;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word1  = 8'd0;
        bus.in_word2  = 4'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset_div_start", 32'(bus.div_start), 32'd0);
        check_eq("reset_out_data", 32'({bus.out_dbz, bus.out_quotient, bus.out_remainder}), 32'd0);
        @(posedge clk); #1;

        run_one(8'd13, 4'd3, 1, 7);
        run_one(8'd20, 4'd0, -1, 2);
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            run_one(ra, rb, (rb != 4'd0) ? 1 : -1, (rb != 4'd0) ? 7 : 2);
        end

        test_stall();
        test_fill();
        test_reset();
        run_one(8'd77, 4'd6, 1, 7);

        pre_hold = 3;
        run_one(8'hC8, 4'hD, 1, 10);
        pre_hold = 0;

        repeat (4) @(posedge clk);
        #1;
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("final_no_overlap_start", 32'(busy_starts), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
